// File: rtl/mac_relu_unit.sv
// mac_relu_unit: two-stage signed multiply-accumulate with a combinational
// ReLU view of the accumulator. Stage 1 registers the full-precision product,
// stage 2 adds it into the accumulator, either saturating or wrapping.
module mac_relu_unit #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 32,
  parameter int SATURATE = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic                     enable,
  input  logic                     acc_clr,
  output logic signed [ACC_W-1:0]  acc,
  output logic signed [ACC_W-1:0]  relu_acc,
  output logic                     busy,
  output logic                     ovf
);

  localparam int PROD_W = 2 * DATA_W;
  // Extra sign bits to bring the product up to the ACC_W+1 wide sum.
  // ACC_W >= 2*DATA_W keeps this at least 1, so no zero replication occurs.
  localparam int EXT_W  = ACC_W + 1 - PROD_W;

  // Stage 1 state
  logic signed [PROD_W-1:0] prod_reg;
  logic                     pipe_valid_reg;

  // Stage 2 state
  logic signed [ACC_W-1:0]  acc_reg;
  logic                     ovf_reg;

  // Operands widened explicitly so the multiply is evaluated at PROD_W bits.
  logic signed [PROD_W-1:0] a_ext;
  logic signed [PROD_W-1:0] b_ext;
  logic signed [PROD_W-1:0] prod_next;

  // One guard bit above the accumulator captures the exact sum.
  logic signed [ACC_W:0]    acc_wide;
  logic signed [ACC_W:0]    prod_wide;
  logic signed [ACC_W:0]    sum_wide;
  logic                     sum_ovf;
  logic signed [ACC_W-1:0]  acc_add;

  assign a_ext     = {{DATA_W{a[DATA_W-1]}}, a};
  assign b_ext     = {{DATA_W{b[DATA_W-1]}}, b};
  assign prod_next = a_ext * b_ext;

  assign acc_wide  = {acc_reg[ACC_W-1], acc_reg};
  assign prod_wide = {{EXT_W{prod_reg[PROD_W-1]}}, prod_reg};
  assign sum_wide  = acc_wide + prod_wide;

  // The sum left the ACC_W range when the guard bit disagrees with the MSB.
  assign sum_ovf   = sum_wide[ACC_W] ^ sum_wide[ACC_W-1];

  generate
    if (SATURATE != 0) begin : g_sat
      // Clamp to the signed extreme on the side the exact sum went out of range.
      always_comb begin
        acc_add = sum_wide[ACC_W-1:0];
        if (sum_ovf) begin
          if (sum_wide[ACC_W]) begin
            acc_add = {1'b1, {(ACC_W-1){1'b0}}};
          end else begin
            acc_add = {1'b0, {(ACC_W-1){1'b1}}};
          end
        end
      end
    end else begin : g_wrap
      // Two's-complement wrap: keep the low ACC_W bits of the exact sum.
      assign acc_add = sum_wide[ACC_W-1:0];
    end
  endgenerate

  // Stage 1: capture the product and whether it belongs to an accepted pair.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prod_reg       <= '0;
      pipe_valid_reg <= 1'b0;
    end else if (acc_clr) begin
      prod_reg       <= '0;
      pipe_valid_reg <= 1'b0;
    end else begin
      prod_reg       <= prod_next;
      pipe_valid_reg <= enable;
    end
  end

  // Stage 2: fold a valid product into the accumulator; overflow flag is sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (acc_clr) begin
      acc_reg <= '0;
      ovf_reg <= 1'b0;
    end else if (pipe_valid_reg) begin
      acc_reg <= acc_add;
      if (sum_ovf) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  assign acc      = acc_reg;
  assign relu_acc = acc_reg[ACC_W-1] ? '0 : acc_reg;
  assign busy     = pipe_valid_reg;
  assign ovf      = ovf_reg;

endmodule

// File: tb/tb_mac_relu_unit.sv
// Scoreboard bench for mac_relu_unit: stimulus pushes hand-computed expected
// state stamped with a cycle number; a monitor pops and compares on negedges.
module tb_mac_relu_unit;

  logic               clk;
  logic               rst;
  logic signed [15:0] a;
  logic signed [15:0] b;
  logic               enable;
  logic               acc_clr;
  logic signed [31:0] acc;
  logic signed [31:0] relu_acc;
  logic               busy;
  logic               ovf;

  mac_relu_unit #(.DATA_W(16), .ACC_W(32), .SATURATE(1)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .enable   (enable),
    .acc_clr  (acc_clr),
    .acc      (acc),
    .relu_acc (relu_acc),
    .busy     (busy),
    .ovf      (ovf)
  );

  typedef struct {
    string              name;
    int                 stamp;
    logic signed [31:0] acc;
    logic signed [31:0] relu;
    logic               busy;
    logic               ovf;
  } exp_t;

  exp_t exp_q[$];
  int   cyc     = 0;
  int   checks  = 0;
  int   errors  = 0;
  bit   stim_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Apply one input set, let the next rising edge sample it, return at edge+1.
  task automatic drive(input logic signed [15:0] av, input logic signed [15:0] bv,
                       input logic en, input logic clr);
    a       = av;
    b       = bv;
    enable  = en;
    acc_clr = clr;
    @(posedge clk);
    #1;
  endtask

  // Expected state after the most recent edge.
  task automatic expect_now(input string name, input logic signed [31:0] e_acc,
                            input logic signed [31:0] e_relu, input logic e_busy,
                            input logic e_ovf);
    exp_t e;
    e.name  = name;
    e.stamp = cyc;
    e.acc   = e_acc;
    e.relu  = e_relu;
    e.busy  = e_busy;
    e.ovf   = e_ovf;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every expectation stamped for the current cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].stamp <= cyc) begin
        e = exp_q.pop_front();
        checks++;
        if (e.stamp != cyc) begin
          errors++;
          $display("FAIL %s: expectation for cycle %0d not checked until cycle %0d",
                   e.name, e.stamp, cyc);
        end else if (acc !== e.acc || relu_acc !== e.relu || busy !== e.busy || ovf !== e.ovf) begin
          errors++;
          $display("FAIL %s: got acc=%0d relu=%0d busy=%0b ovf=%0b, want acc=%0d relu=%0d busy=%0b ovf=%0b",
                   e.name, acc, relu_acc, busy, ovf, e.acc, e.relu, e.busy, e.ovf);
        end else begin
          $display("ok   %s: acc=%0d relu=%0d busy=%0b ovf=%0b", e.name, acc, relu_acc, busy, ovf);
        end
      end
    end
  end

  // Watchdog so the bench always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, stim_done=%0b", stim_done);
    $fatal(1, "timeout");
  end

  logic signed [15:0] win_a [9];
  logic signed [15:0] win_b [9];
  logic signed [15:0] neg_a [9];

  initial begin
    win_a = '{16'sd10, 16'sd20, 16'sd30, 16'sd40, 16'sd50, 16'sd60, 16'sd70, 16'sd80, 16'sd90};
    win_b = '{-16'sd1, -16'sd1, -16'sd1, 16'sd0, 16'sd0, 16'sd0, 16'sd1, 16'sd1, 16'sd1};
    neg_a = '{16'sd70, 16'sd80, 16'sd90, 16'sd40, 16'sd50, 16'sd60, 16'sd10, 16'sd20, 16'sd30};

    rst = 1'b0; a = '0; b = '0; enable = 1'b0; acc_clr = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    expect_now("reset", 0, 0, 1'b0, 1'b0);
    rst = 1'b1;

    // Build acc=500, then reset asynchronously mid-stream.
    drive(0, 0, 1'b0, 1'b1);
    drive(20, 25, 1'b1, 1'b0);
    expect_now("pipe_pending", 0, 0, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0);
    expect_now("acc_500", 500, 500, 1'b0, 1'b0);
    drive(1, 1, 1'b1, 1'b0);
    rst = 1'b0;
    expect_now("async_reset", 0, 0, 1'b0, 1'b0);
    drive(0, 0, 1'b0, 1'b0);
    rst = 1'b1;
    drive(0, 0, 1'b0, 1'b0);
    drive(0, 0, 1'b0, 1'b0);
    expect_now("post_reset", 0, 0, 1'b0, 1'b0);

    // 3x3 window with positive result.
    drive(0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) drive(win_a[i], win_b[i], 1'b1, 1'b0);
    expect_now("win_partial", 90, 90, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0);
    expect_now("win_pos", 180, 180, 1'b0, 1'b0);

    // Same window with rows swapped gives a negative result.
    drive(0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 9; i++) drive(neg_a[i], win_b[i], 1'b1, 1'b0);
    expect_now("neg_partial", -210, 0, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0);
    expect_now("win_neg", -180, 0, 1'b0, 1'b0);

    // Clear priority over a simultaneous pair and over a pending product.
    drive(0, 0, 1'b0, 1'b1);
    drive(3, 4, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0);
    expect_now("acc_12", 12, 12, 1'b0, 1'b0);
    drive(5, 5, 1'b1, 1'b1);
    expect_now("clr_prio", 0, 0, 1'b0, 1'b0);
    drive(0, 0, 1'b0, 1'b0);
    expect_now("clr_discard", 0, 0, 1'b0, 1'b0);
    drive(2, 3, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0);
    expect_now("after_clr", 6, 6, 1'b0, 1'b0);
    drive(7, 7, 1'b1, 1'b0);
    expect_now("stage1_held", 6, 6, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b1);
    drive(0, 0, 1'b0, 1'b0);
    expect_now("stage1_discard", 0, 0, 1'b0, 1'b0);

    // Positive saturation, hold, and clear.
    drive(0, 0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) drive(32767, 32767, 1'b1, 1'b0);
    expect_now("sat_two", 2147352578, 2147352578, 1'b1, 1'b0);
    drive(32767, 32767, 1'b1, 1'b0);
    expect_now("sat_max", 2147483647, 2147483647, 1'b1, 1'b1);
    drive(0, 0, 1'b0, 1'b0);
    expect_now("sat_hold", 2147483647, 2147483647, 1'b0, 1'b1);
    drive(0, 0, 1'b0, 1'b1);
    expect_now("sat_clear", 0, 0, 1'b0, 1'b0);

    // Negative saturation to the minimum.
    for (int i = 0; i < 3; i++) drive(-16'sd32768, 32767, 1'b1, 1'b0);
    expect_now("nsat_two", -2147418112, 0, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0);
    expect_now("nsat_min", 32'sh8000_0000, 0, 1'b0, 1'b1);

    // Bubbles in the enable stream.
    drive(0, 0, 1'b0, 1'b1);
    drive(2, 3, 1'b1, 1'b0);
    expect_now("bub_1", 0, 0, 1'b1, 1'b0);
    drive(9, 9, 1'b0, 1'b0);
    expect_now("bub_2", 6, 6, 1'b0, 1'b0);
    drive(4, 5, 1'b1, 1'b0);
    expect_now("bub_3", 6, 6, 1'b1, 1'b0);
    drive(0, 0, 1'b0, 1'b0);
    expect_now("bub_4", 26, 26, 1'b0, 1'b0);

    stim_done = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s: expectation never checked, got nothing, want acc=%0d", e.name, e.acc);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
